// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared, registered ALU (5-cycle operation).
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority (req0 over req1); default is round-robin.
module alu_arbiter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [2:0]   op0,
   input  logic [2:0]   op1,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done0,
   output logic         done1,
   output logic [N-1:0] res0,
   output logic [N-1:0] res1,
   output logic         zero0,
   output logic         zero1,
   output logic [2:0]   alu_ctl,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_result,
   input  logic         alu_zero
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      CAP   = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [2:0]   ctl_q;
   logic [N-1:0] a_q;
   logic [N-1:0] b_q;
   logic         owner_q;
   logic         any_req;
   logic         take;
   logic         win;

   assign any_req = req0 | req1;
   assign take    = (state == IDLE) && any_req;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign win = ~req0;
`else
   logic last_q;

   // With both requesting, the one not served last wins; otherwise the lone requester.
   always_comb begin
      if (req0 && req1) win = ~last_q;
      else              win = req1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       last_q <= 1'b1;
      else if (take) last_q <= win;
   end
`endif

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = CAP;
         CAP:     state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: grants are combinational from IDLE, so reset is folded in to keep them
   // low while rst is held, even with requests pending.
   always_comb begin
      gnt0  = take && !win && !rst;
      gnt1  = take &&  win && !rst;
      done0 = (state == RESP) && !owner_q;
      done1 = (state == RESP) &&  owner_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctl_q   <= 3'b000;
         a_q     <= '0;
         b_q     <= '0;
         owner_q <= 1'b0;
      end else if (take) begin
         ctl_q   <= win ? op1 : op0;
         a_q     <= win ? a1  : a0;
         b_q     <= win ? b1  : b0;
         owner_q <= win;
      end
   end

   assign alu_ctl = ctl_q;
   assign alu_a   = a_q;
   assign alu_b   = b_q;

   // By CAP the ALU has its result (registered after ISSUE) and zero flag (after WAIT).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res0  <= '0;
         res1  <= '0;
         zero0 <= 1'b0;
         zero1 <= 1'b0;
      end else if (state == CAP) begin
         if (owner_q) begin
            res1  <= alu_result;
            zero1 <= alu_zero;
         end else begin
            res0  <= alu_result;
            zero0 <= alu_zero;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter with a behavioural registered ALU.
// Expectations switch to fixed priority when ALU_ARB_FIXED_PRIO_EN is defined.
module tb_alu_arbiter;
   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [2:0]   op0 = '0, op1 = '0;
   logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         gnt0, gnt1, done0, done1, zero0, zero1;
   logic [N-1:0] res0, res1;
   logic [2:0]   alu_ctl;
   logic [N-1:0] alu_a, alu_b;
   logic [N-1:0] alu_result = '0;
   logic         alu_zero = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   alu_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .res0(res0), .res1(res1), .zero0(zero0), .zero1(zero1),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   always #5 clk = ~clk;

   // Shared ALU: result one edge after its inputs, zero flag one edge after the result.
   always @(posedge clk) begin
      case (alu_ctl)
         3'b000:  alu_result <= alu_a & alu_b;
         3'b001:  alu_result <= alu_a | alu_b;
         3'b010:  alu_result <= ~(alu_a | alu_b);
         3'b011:  alu_result <= alu_a + alu_b;
         3'b100:  alu_result <= alu_a - alu_b;
         3'b101:  alu_result <= alu_a;
         3'b110:  alu_result <= alu_b;
         default: alu_result <= ($signed(alu_a) < $signed(alu_b)) ? N'(1) : '0;
      endcase
      alu_zero <= (alu_result == '0);
   end

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] who_exp;
      logic [N-1:0] res1_exp;
      int n;
      bit seen_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
      who_exp  = 4'b0000;
      res1_exp = '0;
`else
      who_exp  = 4'b1010;
      res1_exp = 32'h0000_000F;
`endif

      // Reset state
      #1 rst = 1'b1;
      step();
      step();
      check("rst_gnt0", gnt0, 0);
      check("rst_gnt1", gnt1, 0);
      check("rst_done", {done1, done0}, 0);
      check("rst_res0", res0, 0);
      check("rst_res1", res1, 0);
      check("rst_zero", {zero1, zero0}, 0);
      check("rst_alu_ctl", alu_ctl, 0);
      check("rst_alu_ab", alu_a | alu_b, 0);
      rst = 1'b0;
      step();

      // req0 only: ADD 5+7
      req0 = 1'b1; op0 = 3'b011; a0 = 5; b0 = 7;
      #1;
      check("add_gnt0", gnt0, 1);
      check("add_gnt1", gnt1, 0);
      step();
      req0 = 1'b0;
      check("add_gnt0_pulse", gnt0, 0);
      check("add_alu_ctl", alu_ctl, 3'b011);
      check("add_alu_a", alu_a, 5);
      check("add_alu_b", alu_b, 7);
      step();
      step();
      check("add_no_early_done", done0, 0);
      step();
      check("add_done0", done0, 1);
      check("add_done1", done1, 0);
      check("add_res0", res0, 12);
      check("add_zero0", zero0, 0);
      check("add_res1_hold", res1, 0);
      check("add_zero1_hold", zero1, 0);
      step();
      check("add_done0_pulse", done0, 0);

      // req1 only: SUB 9-9
      req1 = 1'b1; op1 = 3'b100; a1 = 9; b1 = 9;
      #1;
      check("sub_gnt1", gnt1, 1);
      check("sub_gnt0", gnt0, 0);
      step();
      req1 = 1'b0;
      step();
      step();
      step();
      check("sub_done1", done1, 1);
      check("sub_done0", done0, 0);
      check("sub_res1", res1, 0);
      check("sub_zero1", zero1, 1);
      check("sub_res0_hold", res0, 12);

      // req1 raised during ISSUE of a req0 op: SLT -1<1, then NOR 0,0
      step();
      req0 = 1'b1; op0 = 3'b111; a0 = '1; b0 = 1;
      #1;
      check("slt_gnt0", gnt0, 1);
      step();
      req0 = 1'b0;
      req1 = 1'b1; op1 = 3'b010; a1 = 0; b1 = 0;
      #1;
      check("late_gnt1_issue", gnt1, 0);
      step();
      step();
      step();
      check("slt_done0", done0, 1);
      check("slt_res0", res0, 1);
      check("late_gnt1_resp", gnt1, 0);
      step();
      check("late_gnt1_t5", gnt1, 1);
      check("late_done0_pulse", done0, 0);
      step();
      req1 = 1'b0;
      step();
      step();
      step();
      check("nor_done1", done1, 1);
      check("nor_res1", res1, 32'hFFFF_FFFF);
      check("nor_zero1", zero1, 0);
      check("nor_res0_hold", res0, 1);

      // Contention held from reset: OR 0xF0|0x0F and AND 0xFF&0x0F
      step();
      rst = 1'b1;
      req0 = 1'b1; op0 = 3'b001; a0 = 32'hF0; b0 = 32'h0F;
      req1 = 1'b1; op1 = 3'b000; a1 = 32'hFF; b1 = 32'h0F;
      #1;
      check("rr_rst_gnt", {gnt1, gnt0}, 0);
      check("rr_rst_res0", res0, 0);
      check("rr_rst_res1", res1, 0);
      step();
      rst = 1'b0;
      #1;
      check("rr_first_gnt0", gnt0, 1);
      check("rr_first_gnt1", gnt1, 0);
      for (int g = 1; g < 4; g++) begin
         n = 0;
         do begin
            step();
            n++;
         end while (!(gnt0 || gnt1) && n < 12);
         check($sformatf("rr_spacing_%0d", g), n, 5);
         check($sformatf("rr_gnt1_%0d", g), gnt1, who_exp[g]);
         check($sformatf("rr_gnt0_%0d", g), gnt0, !who_exp[g]);
      end
      check("rr_res0", res0, 32'hFF);
      check("rr_res1", res1, res1_exp);

      // Reset pulsed while in WAIT for req0
      rst = 1'b1;
      req1 = 1'b0;
      req0 = 1'b1; op0 = 3'b011; a0 = 1; b0 = 2;
      step();
      rst = 1'b0;
      #1;
      check("abort_gnt0", gnt0, 1);
      step();
      req0 = 1'b0;
      step();
      check("abort_wait_alu_a", alu_a, 1);
      #2 rst = 1'b1;
      #1;
      check("abort_alu_ctl", alu_ctl, 0);
      check("abort_alu_ab", alu_a | alu_b, 0);
      check("abort_res0", res0, 0);
      check("abort_outs", {gnt1, gnt0, done1, done0, zero1, zero0}, 0);
      step();
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (done0 || done1 || gnt0 || gnt1) seen_done = 1'b1;
         step();
      end
      check("abort_no_done", seen_done, 0);
      req0 = 1'b1;
      #1;
      check("reissue_gnt0", gnt0, 1);
      step();
      req0 = 1'b0;
      step();
      step();
      step();
      check("reissue_done0", done0, 1);
      check("reissue_res0", res0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 32, operand/result width in bits.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  requester k wants an ALU operation.
REQ-005 op0, op1  input  3 each  ALU control code for requester k (000 AND, 001 OR, 010 NOR, 011 ADD, 100 SUB, 101 MFHI, 110 MFLO, 111 SLT).
REQ-006 a0, b0, a1, b1  input  N each  operands for requester k.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse; requester k's op/a/b have been accepted.
REQ-008 done0, done1  output  1 each  one-cycle pulse; res/zero valid for requester k.
REQ-009 res0, res1  output  N each  captured ALU result for requester k.
REQ-010 zero0, zero1  output  1 each  captured ALU zero flag for requester k.
REQ-011 alu_ctl  output  3; alu_a, alu_b  output  N each  drive the shared ALU.
REQ-012 alu_result  input  N; alu_zero  input  1  outputs of the shared ALU.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, CAP, RESP; one transition per clock, strictly in that order, RESP returns to IDLE.
REQ-014 Arbitration occurs only in IDLE; with any reqk high, the winner's op/a/b are latched into internal registers, gntk pulses in that same cycle, and the next state is ISSUE.
REQ-015 In IDLE with no request, the FSM stays in IDLE and no gnt pulses.
REQ-016 Default arbitration is round-robin: a 1-bit last-served pointer; with both requests high, the requester not last served wins; with one request high, that requester wins.
REQ-017 The pointer updates to the winner on every grant.
REQ-018 alu_ctl/alu_a/alu_b are driven from the latched registers and held stable from ISSUE through CAP.
REQ-019 ALU timing: the ALU registers its result at the edge ending ISSUE, and the zero flag one edge later.
REQ-020 In CAP, alu_result and alu_zero are written into res/zero of the granted requester only; the other requester's res/zero hold.
REQ-021 In RESP, donek pulses for exactly one cycle for the granted requester.
REQ-022 Latency: if gntk is in cycle T, donek is in cycle T+4; maximum throughput is one operation per 5 cycles.
REQ-023 res/zero hold their value until the next CAP for the same requester.
REQ-024 Requesters hold reqk/opk/ak/bk stable until gntk; the block samples them only in IDLE.
REQ-025 A req raised during ISSUE..RESP waits and is arbitrated in the next IDLE.
REQ-026 gnt0 and gnt1 are never high together; done0 and done1 are never high together.
REQ-027 MFHI/MFLO codes pass through unchanged; the ALU's HI/LO state is not tracked by this block.

Reset
REQ-028 rst high forces IDLE immediately, regardless of clk.
REQ-029 On reset, all outputs (gnt*, done*, res*, zero*, alu_ctl, alu_a, alu_b) and the latched registers go to 0.
REQ-030 On reset, the pointer is set to last-served = 1, so req0 wins the first contention.
REQ-031 Reset mid-operation aborts the operation: no done pulse is issued for it, and the requester must re-request.

Configuration
REQ-032 Macro ALU_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority; req0 always beats req1 and the pointer is not implemented.
REQ-033 When ALU_ARB_FIXED_PRIO_EN is undefined, the round-robin of REQ-016/017 applies.

Verification
REQ-034 req0 only, ADD, a0=5, b0=7 -> gnt0 at T; done0 at T+4; res0=12, zero0=0; res1/zero1 unchanged.
REQ-035 req1 only, SUB, a1=9, b1=9 -> done1 at T+4; res1=0, zero1=1.
REQ-036 req0 and req1 held high continuously from reset (op0=OR 0xF0|0x0F, op1=AND 0xFF&0x0F) -> grant order 0,1,0,1, grants 5 cycles apart; res0=0xFF, res1=0x0F.
REQ-037 rst pulsed while FSM is in WAIT for req0 -> no done0, all outputs 0, FSM in IDLE; a re-issued req0 completes normally.
REQ-038 ALU_ARB_FIXED_PRIO_EN defined, both requests held high for 3 operations -> gnt0 on all three, gnt1 never.
REQ-039 req1 raised during the ISSUE of a req0 operation -> gnt1 in the IDLE cycle following RESP, i.e. T+5 relative to gnt0.
